tex_column_sequencer: RTL
=========================

TEX_COLUMN_SEQUENCER -- requirements
Module: tex_column_sequencer

Interface
REQ-001 The block SHALL have parameters: SCREEN_WIDTH, default 320, screen columns; SCREEN_HEIGHT, default 180, screen rows; TEX_LATENCY, default 2, texture-unit read latency in cycles; CEIL_COLOR, default 16'h0000, ceiling pixel; FLOOR_COLOR, default 16'h4208, floor pixel.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 The block SHALL have these ports:
pixel_clk_in  in  1  clock.
rst_in  in  1  asynchronous active-high reset.
col_valid_in  in  1  column descriptor valid.
col_ready_out  out  1  descriptor accepted when high with col_valid_in.
col_hcount_in  in  9  column index.
col_wallx_in  in  16  wall hit fraction; bits [7:0] are used downstream.
col_tex_in  in  4  wall material ID.
col_draw_start_in  in  8  first wall row, inclusive.
col_draw_end_in  in  8  last wall row, inclusive.
col_color_in  in  16  flat wall colour for untextured IDs.
tex_req_valid_out  out  1  texture request strobe.
tex_wallx_out  out  16  latched wallX.
tex_vcount_out  out  8  requested row.
tex_id_out  out  4  texture select to texture unit.
tex_pixel_in  in  16  texel, valid TEX_LATENCY cycles after request.
px_valid_out  out  1  framebuffer write strobe.
px_addr_out  out  16  hcount + row*SCREEN_WIDTH.
px_data_out  out  16  pixel colour.
busy_out  out  1  high in any state but IDLE.

Function
REQ-004 FSM states SHALL be IDLE, ISSUE, DRAIN.
REQ-005 col_ready_out SHALL be 1 only in IDLE.
REQ-006 On col_valid_in && col_ready_out, the block SHALL latch all col_* inputs, set row counter to 0 and enter ISSUE on the next cycle.
REQ-007 In ISSUE the row counter SHALL increment by 1 every cycle from 0 to SCREEN_HEIGHT-1, with exactly one row per cycle and no stalls.
REQ-008 Row classification in ISSUE SHALL be:
- row < draw_start: CEIL, checked first.
- row > draw_end: FLOOR.
- otherwise: WALL.
REQ-009 A WALL row whose latched ID is 3, 4 or 5 SHALL be TEXTURED.
- tex_req_valid_out=1 that cycle, with tex_vcount_out=row.
- Every other row SHALL drive tex_req_valid_out=0.
REQ-010 tex_wallx_out and tex_id_out SHALL equal the latched values from acceptance until the block returns to IDLE, because the texture mux is combinational on the ID.
REQ-011 Each ISSUE row SHALL enter a TEX_LATENCY-deep delay line carrying valid, address, source (CEIL/FLOOR/FLAT/TEX) and flat colour.
REQ-012 Exactly TEX_LATENCY cycles after a row is issued, px_valid_out SHALL be 1 for that row.
- px_addr_out = hcount + row*SCREEN_WIDTH, 16-bit, no overflow for defaults.
- px_data_out = CEIL_COLOR, FLOOR_COLOR, col_color_in or tex_pixel_in, per the row's source.
REQ-013 After row SCREEN_HEIGHT-1 the FSM SHALL enter DRAIN for TEX_LATENCY cycles, then IDLE.
- One column takes 1 + SCREEN_HEIGHT + TEX_LATENCY cycles, accept to ready.
- SCREEN_HEIGHT px writes SHALL occur per column, in ascending row order.
REQ-014 If draw_start > draw_end, the block SHALL emit no WALL rows; REQ-008 priority applies.
REQ-015 draw_end ≥ SCREEN_HEIGHT SHALL be treated as SCREEN_HEIGHT-1, with no extra rows.
REQ-016 col_hcount_in ≥ SCREEN_WIDTH SHALL be processed unchanged; the address is not clamped.
REQ-017 col_valid_in outside IDLE SHALL be ignored and SHALL NOT be latched.

Reset
REQ-018 Asserting rst_in SHALL immediately force IDLE, clear the delay line, and drive these outputs to 0: tex_req_valid_out, px_valid_out, px_addr_out, px_data_out, tex_wallx_out, tex_vcount_out, tex_id_out, busy_out.
REQ-019 col_ready_out SHALL be 0 while rst_in=1 and SHALL be 1 from the first clock edge after deassertion.
REQ-020 Reset mid-column SHALL abort the column with no further px_valid_out; the next column SHALL start cleanly from row 0.

Verification
REQ-021 Textured column: hcount=10, tex=3, wallX=16'h0080, start=60, end=119, with stubbed texel=row.
- 60 requests, rows 60..119.
- px rows 0..59 = CEIL_COLOR.
- Rows 60..119 data = row.
- Rows 120..179 = FLOOR_COLOR.
- Addresses 10, 330, … 57290.
- Ready returns 183 cycles after accept.
REQ-022 Flat column: tex=1, color=16'hF800, start=0, end=179.
- Zero tex requests.
- 180 writes of 16'hF800.
REQ-023 Inverted range: start=100, end=50.
- Rows 0..99 CEIL_COLOR, rows 100..179 FLOOR_COLOR.
- No requests.
REQ-024 Reset at row 90: no px_valid_out after reset, busy_out=0.
- The next column (hcount=5) writes address 5 first.
REQ-025 Back-to-back: col_valid_in held high with two descriptors.
- Second is accepted only when col_ready_out=1.
- tex_id_out changes only after the first column's last write.
- No valid pulses while busy.

Source files
------------

// File: rtl/tex_column_sequencer.sv
// Per-column raycaster back end. It takes one column descriptor, walks every screen row and
// classifies it as ceiling, floor, flat wall or textured wall, then writes the pixel once its texel has arrived.
module tex_column_sequencer #(
    parameter int          SCREEN_WIDTH  = 320,
    parameter int          SCREEN_HEIGHT = 180,
    parameter int          TEX_LATENCY   = 2,
    parameter logic [15:0] CEIL_COLOR    = 16'h0000,
    parameter logic [15:0] FLOOR_COLOR   = 16'h4208
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic        col_valid_in,
    output logic        col_ready_out,
    input  logic [8:0]  col_hcount_in,
    input  logic [15:0] col_wallx_in,
    input  logic [3:0]  col_tex_in,
    input  logic [7:0]  col_draw_start_in,
    input  logic [7:0]  col_draw_end_in,
    input  logic [15:0] col_color_in,
    output logic        tex_req_valid_out,
    output logic [15:0] tex_wallx_out,
    output logic [7:0]  tex_vcount_out,
    output logic [3:0]  tex_id_out,
    input  logic [15:0] tex_pixel_in,
    output logic        px_valid_out,
    output logic [15:0] px_addr_out,
    output logic [15:0] px_data_out,
    output logic        busy_out
);
    localparam logic [7:0]  LAST_ROW   = 8'(SCREEN_HEIGHT - 1);
    localparam logic [7:0]  LAST_DRAIN = 8'(TEX_LATENCY - 1);
    localparam logic [15:0] WIDTH16    = 16'(SCREEN_WIDTH);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    typedef enum logic [1:0] {SRC_CEIL, SRC_FLOOR, SRC_FLAT, SRC_TEX} src_t;

    function automatic logic [7:0] sat_row(input logic [7:0] r);
        return (r > LAST_ROW) ? LAST_ROW : r;
    endfunction

    function automatic logic is_textured(input logic [3:0] id);
        return (id == 4'd3) || (id == 4'd4) || (id == 4'd5);
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  row_q, row_d;
    logic [8:0]  hcount_q, hcount_d;
    logic [15:0] wallx_q, wallx_d;
    logic [3:0]  tex_q, tex_d;
    logic [7:0]  start_q, start_d;
    logic [7:0]  end_q, end_d;
    logic [15:0] color_q, color_d;
    logic        issue;
    src_t        row_src;
    logic [15:0] row_addr;

    logic        dly_vld_q   [TEX_LATENCY];
    logic        dly_vld_d   [TEX_LATENCY];
    logic [15:0] dly_addr_q  [TEX_LATENCY];
    logic [15:0] dly_addr_d  [TEX_LATENCY];
    src_t        dly_src_q   [TEX_LATENCY];
    src_t        dly_src_d   [TEX_LATENCY];
    logic [15:0] dly_color_q [TEX_LATENCY];
    logic [15:0] dly_color_d [TEX_LATENCY];

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        hcount_d = hcount_q;
        wallx_d  = wallx_q;
        tex_d    = tex_q;
        start_d  = start_q;
        end_d    = end_q;
        color_d  = color_q;
        issue    = 1'b0;
        case (state_q)
            IDLE: begin
                if (col_valid_in) begin
                    hcount_d = col_hcount_in;
                    wallx_d  = col_wallx_in;
                    tex_d    = col_tex_in;
                    start_d  = col_draw_start_in;
                    end_d    = sat_row(col_draw_end_in);
                    color_d  = col_color_in;
                    row_d    = '0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                issue = 1'b1;
                if (row_q == LAST_ROW) begin
                    row_d   = '0;
                    state_d = DRAIN;
                end else begin
                    row_d = row_q + 8'd1;
                end
            end
            DRAIN: begin
                // Row counter is reused to time out the texel pipeline.
                if (row_q == LAST_DRAIN) begin
                    row_d   = '0;
                    state_d = IDLE;
                end else begin
                    row_d = row_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        // Ceiling test first so an inverted start/end range yields no wall rows.
        if (row_q < start_q)      row_src = SRC_CEIL;
        else if (row_q > end_q)   row_src = SRC_FLOOR;
        else if (is_textured(tex_q)) row_src = SRC_TEX;
        else                      row_src = SRC_FLAT;
        row_addr = {7'd0, hcount_q} + ({8'd0, row_q} * WIDTH16);
    end

    always_comb begin
        dly_vld_d[0]   = issue;
        dly_addr_d[0]  = row_addr;
        dly_src_d[0]   = row_src;
        dly_color_d[0] = color_q;
        for (int i = 1; i < TEX_LATENCY; i++) begin
            dly_vld_d[i]   = dly_vld_q[i-1];
            dly_addr_d[i]  = dly_addr_q[i-1];
            dly_src_d[i]   = dly_src_q[i-1];
            dly_color_d[i] = dly_color_q[i-1];
        end
    end

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            row_q    <= '0;
            hcount_q <= '0;
            wallx_q  <= '0;
            tex_q    <= '0;
            start_q  <= '0;
            end_q    <= '0;
            color_q  <= '0;
            for (int i = 0; i < TEX_LATENCY; i++) begin
                dly_vld_q[i]   <= 1'b0;
                dly_addr_q[i]  <= '0;
                dly_src_q[i]   <= SRC_CEIL;
                dly_color_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            hcount_q <= hcount_d;
            wallx_q  <= wallx_d;
            tex_q    <= tex_d;
            start_q  <= start_d;
            end_q    <= end_d;
            color_q  <= color_d;
            for (int i = 0; i < TEX_LATENCY; i++) begin
                dly_vld_q[i]   <= dly_vld_d[i];
                dly_addr_q[i]  <= dly_addr_d[i];
                dly_src_q[i]   <= dly_src_d[i];
                dly_color_q[i] <= dly_color_d[i];
            end
        end
    end

    // Last delay stage lines up with the texel returned for that row.
    always_comb begin
        px_data_out = '0;
        if (dly_vld_q[TEX_LATENCY-1]) begin
            case (dly_src_q[TEX_LATENCY-1])
                SRC_CEIL:  px_data_out = CEIL_COLOR;
                SRC_FLOOR: px_data_out = FLOOR_COLOR;
                SRC_FLAT:  px_data_out = dly_color_q[TEX_LATENCY-1];
                default:   px_data_out = tex_pixel_in;
            endcase
        end
    end

    assign px_valid_out      = dly_vld_q[TEX_LATENCY-1];
    assign px_addr_out       = dly_addr_q[TEX_LATENCY-1];
    assign col_ready_out     = (state_q == IDLE) && !rst_in;
    assign busy_out          = (state_q != IDLE);
    assign tex_req_valid_out = issue && (row_src == SRC_TEX);
    assign tex_vcount_out    = row_q;
    assign tex_wallx_out     = wallx_q;
    assign tex_id_out        = tex_q;
endmodule
